t03_dpu_frame_ctrl: RTL and testbench

T03_DPU_FRAME_CTRL -- requirements
Module: t03_dpu_frame_ctrl

---
 rtl/t03_dpu_frame_ctrl.sv | 155 +++++++++++++++
 tb/tb_t03_dpu_frame_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/t03_dpu_frame_ctrl.sv
// Display frame controller: VGA-style timing plus double-buffered game/player registers.
// Optional register readback is enabled by defining T03_DPU_READBACK_EN.
module t03_dpu_frame_ctrl #(
  parameter int          NUM_PLAYERS = 2,
  parameter int          H_ACTIVE    = 640,
  parameter int          H_FP        = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_BP        = 48,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_FP        = 10,
  parameter int          V_SYNC      = 2,
  parameter int          V_BP        = 33,
  parameter logic [31:0] BASE_ADDR   = 32'hFF000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [31:0]                address,
  input  logic [31:0]                wdata,
  output logic                       wr_ack,
  input  logic                       rd_en,
  output logic [31:0]                rdata,
  output logic                       rd_valid,
  output logic [2:0]                 game_state,
  output logic [11*NUM_PLAYERS-1:0]  px,
  output logic [11*NUM_PLAYERS-1:0]  py,
  output logic [2*NUM_PLAYERS-1:0]   pstate,
  output logic [4*NUM_PLAYERS-1:0]   phealth,
  output logic [NUM_PLAYERS-1:0]     pleft,
  output logic [10:0]                Hcnt,
  output logic [10:0]                Vcnt,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       at_display,
  output logic                       frame_start,
  output logic [15:0]                frame_count
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST = 11'(HT - 1);
  localparam logic [10:0] V_LAST = 11'(VT - 1);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] VA     = 11'(V_ACTIVE);

  logic        h_wrap, commit;
  logic [10:0] h_nxt, v_nxt;

  assign h_wrap = (Hcnt == H_LAST);
  assign commit = h_wrap && (Vcnt == V_LAST);

  always_comb begin
    h_nxt = h_wrap ? 11'd0 : Hcnt + 11'd1;
    v_nxt = Vcnt;
    if (h_wrap) v_nxt = (Vcnt == V_LAST) ? 11'd0 : Vcnt + 11'd1;
  end

  // Timing outputs are decoded from the next counter values so they line up with Hcnt/Vcnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      Hcnt        <= '0;
      Vcnt        <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      at_display  <= (HA != 11'd0) && (VA != 11'd0);
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      Hcnt        <= h_nxt;
      Vcnt        <= v_nxt;
      hsync       <= !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
      vsync       <= !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
      at_display  <= (h_nxt < HA) && (v_nxt < VA);
      frame_start <= commit;
      if (commit) frame_count <= frame_count + 16'd1;
    end
  end

  logic [31:0] offset;
  logic [29:0] idx;
  logic        aligned;
  logic [28:0] wr_fields;

  assign offset    = address - BASE_ADDR;
  assign idx       = offset[31:2];
  assign aligned   = (offset[1:0] == 2'b00);
  assign wr_fields = {wdata[28], (wdata[27:24] > 4'd9) ? 4'd9 : wdata[27:24], wdata[23:0]};

  logic [2:0]                   sh_gs, act_gs;
  logic [NUM_PLAYERS-1:0][28:0] sh_pl, act_pl;

  // Commit samples shadows before this cycle's write lands, so a coincident write waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_gs  <= '0;
      sh_pl  <= '0;
      act_gs <= '0;
      act_pl <= '0;
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= wr_en;
      if (wr_en && aligned) begin
        if (idx == 30'd0) sh_gs <= wdata[2:0];
        for (int i = 0; i < NUM_PLAYERS; i++)
          if (idx == 30'(i + 1)) sh_pl[i] <= wr_fields;
      end
      if (commit) begin
        act_gs <= sh_gs;
        act_pl <= sh_pl;
      end
    end
  end

  assign game_state = act_gs;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pl
    assign px[11*g +: 11]     = act_pl[g][10:0];
    assign py[11*g +: 11]     = act_pl[g][21:11];
    assign pstate[2*g +: 2]   = act_pl[g][23:22];
    assign phealth[4*g +: 4]  = act_pl[g][27:24];
    assign pleft[g]           = act_pl[g][28];
  end

`ifdef T03_DPU_READBACK_EN
  logic unused_bits;
  assign unused_bits = ^wdata[31:29];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rdata    <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rdata <= '0;
        if (aligned) begin
          if (idx == 30'd0) rdata <= {29'd0, sh_gs};
          for (int i = 0; i < NUM_PLAYERS; i++)
            if (idx == 30'(i + 1)) rdata <= {3'd0, sh_pl[i]};
        end
      end
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{wdata[31:29], rd_en};
  assign rdata       = '0;
  assign rd_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_t03_dpu_frame_ctrl.sv
// Bench for t03_dpu_frame_ctrl: shrunk timing, write table, ack/read scoreboard, commit corners.
module tb_t03_dpu_frame_ctrl;
  localparam int NP = 2;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int N  = HT * VT;

  logic clk, rst, wr_en, rd_en;
  logic [31:0] address, wdata, rdata;
  logic wr_ack, rd_valid, hsync, vsync, at_display, frame_start;
  logic [2:0] game_state;
  logic [11*NP-1:0] px, py;
  logic [2*NP-1:0] pstate;
  logic [4*NP-1:0] phealth;
  logic [NP-1:0] pleft;
  logic [10:0] Hcnt, Vcnt;
  logic [15:0] frame_count;

  t03_dpu_frame_ctrl #(
    .NUM_PLAYERS(NP), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .BASE_ADDR(32'hFF000000)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .address(address), .wdata(wdata),
    .wr_ack(wr_ack), .rd_en(rd_en), .rdata(rdata), .rd_valid(rd_valid),
    .game_state(game_state), .px(px), .py(py), .pstate(pstate), .phealth(phealth),
    .pleft(pleft), .Hcnt(Hcnt), .Vcnt(Vcnt), .hsync(hsync), .vsync(vsync),
    .at_display(at_display), .frame_start(frame_start), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int c; logic [31:0] d; } rd_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int tgt; logic [31:0] val; } vec_t;

  int errors = 0, checks = 0, cyc = 0;
  int ack_q[$];
  rd_t rd_q[$];
  logic [2:0]  sh_gs = '0, exp_gs = '0;
  logic [31:0] sh_pl[NP], exp_pl[NP];
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every cycle: pop expected acks/reads when due, otherwise require the strobes idle.
  task automatic tick();
    rd_t r;
    @(posedge clk); #1;
    cyc++;
    if (ack_q.size() > 0 && ack_q[0] == cyc) begin
      void'(ack_q.pop_front());
      chk("wr_ack_pulse", wr_ack, 1);
    end else chk("wr_ack_idle", wr_ack, 0);
    if (rd_q.size() > 0 && rd_q[0].c == cyc) begin
      r = rd_q.pop_front();
`ifdef T03_DPU_READBACK_EN
      chk("rd_valid_pulse", rd_valid, 1);
      chk("rdata", rdata, r.d);
`else
      chk("rd_valid_off", rd_valid, 0);
      chk("rdata_off", rdata, 0);
`endif
    end else chk("rd_valid_idle", rd_valid, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; address = a; wdata = d;
    ack_q.push_back(cyc + 1);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d);
    rd_t r;
    rd_en = 1'b1; address = a;
    r.c = cyc + 1; r.d = d;
    rd_q.push_back(r);
  endtask

  task automatic wait_commit();
    int n = 0;
    while (!(Hcnt == 11'(HT-1) && Vcnt == 11'(VT-1)) && n < 2*N) begin tick(); n++; end
    chk("commit_found", {Hcnt, Vcnt}, {11'(HT-1), 11'(VT-1)});
  endtask

  task automatic do_commit();
    wait_commit();
    tick();
    exp_gs = sh_gs;
    for (int p = 0; p < NP; p++) exp_pl[p] = sh_pl[p];
    chk("frame_start_commit", frame_start, 1);
  endtask

  task automatic chk_active(input string tag);
    chk({tag, "_gs"}, game_state, exp_gs);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s_px%0d", tag, p), px[11*p +: 11], exp_pl[p][10:0]);
      chk($sformatf("%s_py%0d", tag, p), py[11*p +: 11], exp_pl[p][21:11]);
      chk($sformatf("%s_st%0d", tag, p), pstate[2*p +: 2], exp_pl[p][23:22]);
      chk($sformatf("%s_hp%0d", tag, p), phealth[4*p +: 4], exp_pl[p][27:24]);
      chk($sformatf("%s_lf%0d", tag, p), pleft[p], exp_pl[p][28]);
    end
  endtask

  initial begin
    int tm_err, hs_low, vs_low, eh, ev, n;
    tbl[0] = '{32'hFF000004, 32'h0A00_C864, 1, 32'h0900_C864};
    tbl[1] = '{32'hFF000008, 32'h1000_0005, 2, 32'h1000_0005};
    tbl[2] = '{32'hFF000000, 32'h0000_0005, 0, 32'h0000_0005};
    tbl[3] = '{32'hFF00000C, 32'hFFFF_FFFF, -1, 32'h0};
    tbl[4] = '{32'hFF000002, 32'h0000_0123, -1, 32'h0};
    tbl[5] = '{32'hFEFFFFFC, 32'h0000_0001, -1, 32'h0};
    for (int p = 0; p < NP; p++) begin sh_pl[p] = '0; exp_pl[p] = '0; end

    // Reset with a write and read issued alongside; neither may survive.
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; address = 32'hFF000004; wdata = 32'h0300_0007;
    repeat (3) tick();
    chk("rst_hcnt", Hcnt, 0);
    chk("rst_vcnt", Vcnt, 0);
    chk("rst_fcount", frame_count, 0);
    chk("rst_fstart", frame_start, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_at_display", at_display, 1);
    chk_active("rst");
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;

    // One full frame of timing against a bench-side position counter.
    tm_err = 0; hs_low = 0; vs_low = 0;
    for (int k = 1; k <= N; k++) begin
      tick();
      eh = k % HT; ev = (k / HT) % VT;
      if (Hcnt != 11'(eh) || Vcnt != 11'(ev)) tm_err++;
      if (hsync !== !(eh >= HA+HF && eh < HA+HF+HS)) tm_err++;
      if (vsync !== !(ev >= VA+VF && ev < VA+VF+VS)) tm_err++;
      if (at_display !== (eh < HA && ev < VA)) tm_err++;
      if (frame_start !== (k == N)) tm_err++;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
    end
    chk("timing_mismatches", tm_err, 0);
    chk("hsync_low_cycles", hs_low, HS*VT);
    chk("vsync_low_cycles", vs_low, VS*HT);
    chk("frame_count_1", frame_count, 1);
    chk_active("rst_write_dropped");

    // Mid-frame table of writes, applied back-to-back.
    repeat (60) tick();
    for (int i = 0; i < 6; i++) begin
      wr(tbl[i].addr, tbl[i].data);
      tick();
      if (tbl[i].tgt == 0) sh_gs = tbl[i].val[2:0];
      else if (tbl[i].tgt > 0) sh_pl[tbl[i].tgt-1] = tbl[i].val;
    end
    wr_en = 1'b0;
    rd(32'hFF000008, sh_pl[1]); tick();
    rd(32'hFF000004, sh_pl[0]); tick();
    rd(32'hFF00000C, 32'h0);    tick();
    rd_en = 1'b0;
    tick();
    chk_active("pre_commit");
    wait_commit();
    chk_active("on_commit_cycle");
    tick();
    exp_gs = sh_gs;
    for (int p = 0; p < NP; p++) exp_pl[p] = sh_pl[p];
    chk("frame_start_2", frame_start, 1);
    chk("frame_count_2", frame_count, 2);
    chk_active("after_commit");
    chk("px0_100", px[10:0], 100);
    chk("py0_25", py[10:0], 25);
    chk("health0_clamp", phealth[3:0], 9);

    // Write landing exactly on the commit cycle.
    wait_commit();
    wr(32'hFF000000, 32'h3);
    tick();
    wr_en = 1'b0;
    chk("frame_start_3", frame_start, 1);
    chk_active("commit_coincide");
    sh_gs = 3'd3;
    do_commit();
    chk_active("commit_coincide_next");
    chk("gs_is_3", game_state, 3);

    // Consecutive writes; last write per register wins.
    repeat (20) tick();
    wr(32'hFF000004, 32'h0F40_0ABC); tick();
    wr(32'hFF000004, 32'h0200_0321); tick();
    wr(32'hFF000000, 32'h0000_0001); tick();
    wr_en = 1'b0;
    sh_pl[0] = 32'h0200_0321; sh_gs = 3'd1;
    rd(32'hFF000004, sh_pl[0]); tick();
    rd(32'hFF000000, 32'h1);    tick();
    rd_en = 1'b0;
    do_commit();
    chk_active("last_wins");

    // Reset mid-line, again with a write/read in the reset cycle.
    n = 0;
    while (Hcnt != 11'd10 && n < 2*HT) begin tick(); n++; end
    chk("reach_hcnt10", Hcnt, 10);
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; address = 32'hFF000008; wdata = 32'h0123_4567;
    tick();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    sh_gs = '0; exp_gs = '0;
    for (int p = 0; p < NP; p++) begin sh_pl[p] = '0; exp_pl[p] = '0; end
    chk("midrst_hcnt", Hcnt, 0);
    chk("midrst_vcnt", Vcnt, 0);
    chk("midrst_hsync", hsync, 1);
    chk("midrst_vsync", vsync, 1);
    chk("midrst_fcount", frame_count, 0);
    chk_active("midrst");
    do_commit();
    chk("midrst_fcount_1", frame_count, 1);
    chk_active("midrst_commit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
